// File: rtl/reg_bank_write_arbiter.sv
// rtl/reg_bank_write_arbiter.sv - round-robin write-port arbiter for an enable-loaded register bank
//
// Shares the single write path of an NREG-entry register bank among three
// requesters that each use a 4-phase req/done handshake.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   req[2:0]       request per requester (bit i = requester i)
//   addr0..addr2   target register index per requester, stable while req[i]=1
//   data0..data2   write data per requester, stable while req[i]=1
//   wr_en          one-hot load enable to the bank (single-cycle pulse)
//   wr_data        shared data bus to all bank D inputs
//   gnt            one-hot, requester currently being served
//   done           per-requester completion flag
//   err            raised with done when the served address is >= NREG
//   busy           high whenever the controller is not idle

module reg_bank_write_arbiter #(
    parameter int N    = 8,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      req,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [AW-1:0]   addr2,
    input  logic [N-1:0]    data0,
    input  logic [N-1:0]    data1,
    input  logic [N-1:0]    data2,
    output logic [NREG-1:0] wr_en,
    output logic [N-1:0]    wr_data,
    output logic [2:0]      gnt,
    output logic [2:0]      done,
    output logic            err,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      ptr, ptr_nxt;
    logic [1:0]      win, win_nxt;
    logic [AW-1:0]   addr_l, addr_l_nxt;
    logic [N-1:0]    data_l, data_l_nxt;
    logic            err_flag, err_flag_nxt;

    logic [NREG-1:0] wr_en_nxt;
    logic [N-1:0]    wr_data_nxt;
    logic [2:0]      gnt_nxt, done_nxt;
    logic            err_nxt, busy_nxt;

    logic [1:0]      pick, cand1, cand2;
    logic            in_range;

    function automatic logic [1:0] inc_mod3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Round-robin scan: ptr first, then ptr+1, then ptr+2 (mod 3).
    always_comb begin
        cand1 = inc_mod3(ptr);
        cand2 = inc_mod3(cand1);
        if (req[ptr])
            pick = ptr;
        else if (req[cand1])
            pick = cand1;
        else
            pick = cand2;
    end

    // Address is never truncated; anything past the last register is an error.
    assign in_range = (32'(addr_l) < 32'(NREG));

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        win_nxt      = win;
        addr_l_nxt   = addr_l;
        data_l_nxt   = data_l;
        err_flag_nxt = err_flag;
        wr_en_nxt    = '0;
        wr_data_nxt  = wr_data;
        gnt_nxt      = gnt;
        done_nxt     = done;
        err_nxt      = err;

        case (state)
            IDLE: begin
                if (|req) begin
                    win_nxt   = pick;
                    gnt_nxt   = 3'b001 << pick;
                    state_nxt = LOAD;
                    case (pick)
                        2'd0:    begin addr_l_nxt = addr0; data_l_nxt = data0; end
                        2'd1:    begin addr_l_nxt = addr1; data_l_nxt = data1; end
                        default: begin addr_l_nxt = addr2; data_l_nxt = data2; end
                    endcase
                end
            end
            LOAD: begin
                wr_data_nxt  = data_l;
                err_flag_nxt = !in_range;
                if (in_range)
                    wr_en_nxt[addr_l] = 1'b1;
                ptr_nxt   = inc_mod3(win);
                state_nxt = ACK;
            end
            ACK: begin
                // An early req drop still lands here after the load, so the
                // transaction closes out on the first ACK cycle.
                if (req[win]) begin
                    done_nxt = 3'b001 << win;
                    err_nxt  = err_flag;
                end else begin
                    done_nxt  = 3'b000;
                    gnt_nxt   = 3'b000;
                    err_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                gnt_nxt   = 3'b000;
                done_nxt  = 3'b000;
                err_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            win      <= 2'd0;
            addr_l   <= '0;
            data_l   <= '0;
            err_flag <= 1'b0;
            wr_en    <= '0;
            wr_data  <= '0;
            gnt      <= 3'b000;
            done     <= 3'b000;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            win      <= win_nxt;
            addr_l   <= addr_l_nxt;
            data_l   <= data_l_nxt;
            err_flag <= err_flag_nxt;
            wr_en    <= wr_en_nxt;
            wr_data  <= wr_data_nxt;
            gnt      <= gnt_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// tb/tb_reg_bank_write_arbiter.sv - scoreboard bench for reg_bank_write_arbiter

module tb_reg_bank_write_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req, req_b;
    logic [2:0] addr0, addr1, addr2;
    logic [7:0] data0, data1, data2;

    logic [7:0] wr_en, wr_data;
    logic [2:0] gnt, done;
    logic       err, busy;

    logic [5:0] wr_en_b;
    logic [7:0] wr_data_b;
    logic [2:0] gnt_b, done_b;
    logic       err_b, busy_b;

    always #5 clk = ~clk;

    reg_bank_write_arbiter #(.N(8), .NREG(8), .AW(3)) u_dut (
        .clk(clk), .reset(reset), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .data0(data0), .data1(data1), .data2(data2),
        .wr_en(wr_en), .wr_data(wr_data), .gnt(gnt), .done(done),
        .err(err), .busy(busy)
    );

    reg_bank_write_arbiter #(.N(8), .NREG(6), .AW(3)) u_dut6 (
        .clk(clk), .reset(reset), .req(req_b),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .data0(data0), .data1(data1), .data2(data2),
        .wr_en(wr_en_b), .wr_data(wr_data_b), .gnt(gnt_b), .done(done_b),
        .err(err_b), .busy(busy_b)
    );

    logic [7:0] bank [8] = '{default: 8'h00};
    always @(posedge clk)
        for (int i = 0; i < 8; i++)
            if (wr_en[i]) bank[i] <= wr_data;

    typedef struct {
        logic [2:0] gnt;
        logic [7:0] we;
        logic [7:0] data;
        logic       err;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];

    int checks = 0;
    int errors = 0;

    int         load_cnt [2];
    logic [7:0] pwe [2];
    logic [7:0] lwe [2];
    logic [7:0] lwd [2];
    logic [2:0] pdone [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input int id, input logic [2:0] g, input logic [7:0] we,
                            input logic [7:0] data, input logic e);
        rec_t r;
        r.gnt = g; r.we = we; r.data = data; r.err = e;
        if (id == 0) q0.push_back(r);
        else         q1.push_back(r);
    endtask

    task automatic mon_step(input int id, input logic [7:0] we, input logic [7:0] wd,
                            input logic [2:0] g, input logic [2:0] d, input logic e);
        rec_t r;
        int   qsz;
        if (we != 8'h00) begin
            chk("wr_en_onehot", 32'($onehot(we)), 32'd1);
            chk("wr_en_single_cycle", 32'(pwe[id]), 32'd0);
            load_cnt[id]++;
            lwe[id] = we;
            lwd[id] = wd;
        end
        if (d != 3'b000 && pdone[id] == 3'b000) begin
            qsz = (id == 0) ? q0.size() : q1.size();
            if (qsz == 0) begin
                chk("unexpected_done", 32'(d), 32'd0);
            end else begin
                r = (id == 0) ? q0.pop_front() : q1.pop_front();
                chk("sb_gnt", 32'(g), 32'(r.gnt));
                chk("sb_done", 32'(d), 32'(r.gnt));
                chk("sb_err", 32'(e), 32'(r.err));
                chk("sb_wr_en", 32'(lwe[id]), 32'(r.we));
                chk("sb_load_count", 32'(load_cnt[id]), (r.we != 8'h00) ? 32'd1 : 32'd0);
                if (r.we != 8'h00)
                    chk("sb_wr_data", 32'(lwd[id]), 32'(r.data));
            end
            load_cnt[id] = 0;
            lwe[id]      = 8'h00;
        end
        pwe[id]   = we;
        pdone[id] = d;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                load_cnt[i] = 0; pwe[i] = 8'h00; lwe[i] = 8'h00; lwd[i] = 8'h00; pdone[i] = 3'b000;
            end
        end else begin
            mon_step(0, wr_en, wr_data, gnt, done, err);
            mon_step(1, {2'b00, wr_en_b}, wr_data_b, gnt_b, done_b, err_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit b, input int w);
        int n = 0;
        while (!(b ? done_b[w] : done[w]) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!(b ? done_b[w] : done[w]))
            chk("timeout_done", 32'(b ? done_b : done), 32'(3'b001 << w));
    endtask

    task automatic serve(input bit b, input int w);
        wait_done(b, w);
        if (b) req_b[w] = 1'b0;
        else   req[w]   = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; req = 3'b000; req_b = 3'b000;
        addr0 = 3'd0; addr1 = 3'd0; addr2 = 3'd0;
        data0 = 8'h00; data1 = 8'h00; data2 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en_b", 32'(wr_en_b), 32'd0);
        reset = 1'b0;
        tick();

        // single write with exact latency
        addr0 = 3'd3; data0 = 8'hA5;
        exp_push(0, 3'b001, 8'h08, 8'hA5, 1'b0);
        req = 3'b001;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_wr_en_early", 32'(wr_en), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        tick();
        chk("t1_wr_en", 32'(wr_en), 32'h08);
        chk("t1_wr_data", 32'(wr_data), 32'hA5);
        chk("t1_done_early", 32'(done), 32'h0);
        tick();
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_wr_en_off", 32'(wr_en), 32'h0);
        tick(); tick();
        chk("t1_done_hold", 32'(done), 32'h1);
        req[0] = 1'b0;
        tick();
        chk("t1_done_clr", 32'(done), 32'h0);
        chk("t1_gnt_clr", 32'(gnt), 32'h0);
        chk("t1_busy_clr", 32'(busy), 32'h0);
        chk("t1_bank3", 32'(bank[3]), 32'hA5);

        // simultaneous requests from a freshly reset pointer
        reset = 1'b1; tick(); reset = 1'b0; tick();
        addr0 = 3'd0; addr1 = 3'd1; addr2 = 3'd2;
        data0 = 8'h11; data1 = 8'h22; data2 = 8'h33;
        exp_push(0, 3'b001, 8'h01, 8'h11, 1'b0);
        exp_push(0, 3'b010, 8'h02, 8'h22, 1'b0);
        exp_push(0, 3'b100, 8'h04, 8'h33, 1'b0);
        req = 3'b111;
        serve(0, 0); serve(0, 1); serve(0, 2);
        chk("t2_bank0", 32'(bank[0]), 32'h11);
        chk("t2_bank1", 32'(bank[1]), 32'h22);
        chk("t2_bank2", 32'(bank[2]), 32'h33);

        // fairness: requester 0 re-raises immediately, requester 2 is not skipped
        addr0 = 3'd4; data0 = 8'h40; addr2 = 3'd5; data2 = 8'h55;
        exp_push(0, 3'b001, 8'h10, 8'h40, 1'b0);
        exp_push(0, 3'b100, 8'h20, 8'h55, 1'b0);
        exp_push(0, 3'b001, 8'h10, 8'h41, 1'b0);
        exp_push(0, 3'b100, 8'h20, 8'h56, 1'b0);
        req = 3'b101;
        serve(0, 0); data0 = 8'h41; req[0] = 1'b1;
        serve(0, 2); data2 = 8'h56; req[2] = 1'b1;
        serve(0, 0);
        serve(0, 2);

        // NREG=6 instance: last valid register, then out-of-range address
        addr1 = 3'd5; data1 = 8'h5A;
        exp_push(1, 3'b010, 8'h20, 8'h5A, 1'b0);
        req_b = 3'b010;
        serve(1, 1);
        addr1 = 3'd7; data1 = 8'h77;
        exp_push(1, 3'b010, 8'h00, 8'h00, 1'b1);
        req_b = 3'b010;
        wait_done(1, 1);
        chk("t4_err", 32'(err_b), 32'h1);
        chk("t4_busy", 32'(busy_b), 32'h1);
        req_b[1] = 1'b0;
        tick();
        chk("t4_err_clr", 32'(err_b), 32'h0);
        chk("t4_done_clr", 32'(done_b), 32'h0);

        // reset during LOAD aborts; pointer restarts at 0
        addr0 = 3'd6; data0 = 8'h60;
        exp_push(0, 3'b001, 8'h40, 8'h60, 1'b0);
        req = 3'b001;
        serve(0, 0);
        addr0 = 3'd7; data0 = 8'h70; addr2 = 3'd7; data2 = 8'h72;
        req = 3'b101;
        tick();
        chk("t5_gnt_before_rst", 32'(gnt), 32'h4);
        reset = 1'b1;
        #1;
        chk("t5_rst_wr_en", 32'(wr_en), 32'h0);
        chk("t5_rst_gnt", 32'(gnt), 32'h0);
        chk("t5_rst_done", 32'(done), 32'h0);
        tick(); tick();
        chk("t5_bank7_untouched", 32'(bank[7]), 32'h00);
        reset = 1'b0;
        exp_push(0, 3'b001, 8'h80, 8'h70, 1'b0);
        exp_push(0, 3'b100, 8'h80, 8'h72, 1'b0);
        serve(0, 0);
        serve(0, 2);
        chk("t5_bank7", 32'(bank[7]), 32'h72);

        // held req keeps ACK; waiting requester served only after release
        addr0 = 3'd2; data0 = 8'hC2; addr2 = 3'd0; data2 = 8'hD0;
        exp_push(0, 3'b001, 8'h04, 8'hC2, 1'b0);
        exp_push(0, 3'b100, 8'h01, 8'hD0, 1'b0);
        req = 3'b001;
        tick();
        req[2] = 1'b1;
        wait_done(0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_hold_busy", 32'(busy), 32'h1);
            chk("t6_hold_wr_en", 32'(wr_en), 32'h0);
            chk("t6_hold_gnt", 32'(gnt), 32'h1);
        end
        req[0] = 1'b0;
        tick();
        serve(0, 2);
        tick();
        chk("t6_bank2", 32'(bank[2]), 32'hC2);
        chk("t6_bank0", 32'(bank[0]), 32'hD0);
        chk("bank4", 32'(bank[4]), 32'h41);
        chk("bank5", 32'(bank[5]), 32'h56);
        chk("bank6", 32'(bank[6]), 32'h60);
        chk("sb_q0_drained", 32'(q0.size()), 32'd0);
        chk("sb_q1_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
